// File: rtl/alu_cmd_driver.sv
// alu_cmd_driver: accepts ALU commands, drives the ALU, captures and checks its result.
// Latency: accept at edge N, result captured (rsp_valid high) at edge N+1+ALU_LATENCY.
// Backpressure: one command outstanding; cmd_ready low until the response handshakes.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   cmd_valid/ready, cmd_op/a/b    command stream in
//   alu_opcode/a/b, alu_result     registered ALU drive, ALU result in
//   rsp_valid/ready                response stream out
//   rsp_result/expected/mismatch   captured result, model result, compare flag
//   cmd_count, err_count           saturating accept / mismatch counters
module alu_cmd_driver #(
    parameter int ALU_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [3:0]  cmd_op,
    input  logic [7:0]  cmd_a,
    input  logic [7:0]  cmd_b,
    output logic [3:0]  alu_opcode,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    input  logic [8:0]  alu_result,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [8:0]  rsp_result,
    output logic [8:0]  rsp_expected,
    output logic        rsp_mismatch,
    output logic [15:0] cmd_count,
    output logic [15:0] err_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Counter only needs to reach ALU_LATENCY.
    localparam int CW = (ALU_LATENCY < 1) ? 1 : $clog2(ALU_LATENCY + 1);

    state_t          state_q, state_d;
    logic [CW-1:0]   wait_cnt_q, wait_cnt_d;
    logic [3:0]      opcode_q, opcode_d;
    logic [7:0]      a_q, a_d;
    logic [7:0]      b_q, b_d;
    logic [8:0]      result_q, result_d;
    logic [8:0]      expected_q, expected_d;
    logic            mismatch_q, mismatch_d;
    logic [15:0]     cmd_count_q, cmd_count_d;
    logic [15:0]     err_count_q, err_count_d;

    // Reference model; operands zero-extended so SUB wraps mod 512.
    function automatic logic [8:0] model(input logic [3:0] op,
                                         input logic [7:0] a,
                                         input logic [7:0] b);
        logic [8:0] ax;
        logic [8:0] bx;
        ax = {1'b0, a};
        bx = {1'b0, b};
        case (op)
            4'b0000: model = ax + bx;
            4'b0001: model = ax - bx;
            4'b0010: model = ax & bx;
            4'b0011: model = ax | bx;
            4'b0100: model = ax ^ bx;
            default: model = 9'h000;
        endcase
    endfunction

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        opcode_d    = opcode_q;
        a_d         = a_q;
        b_d         = b_q;
        result_d    = result_q;
        expected_d  = expected_q;
        mismatch_d  = mismatch_q;
        cmd_count_d = cmd_count_q;
        err_count_d = err_count_q;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    opcode_d   = cmd_op;
                    a_d        = cmd_a;
                    b_d        = cmd_b;
                    expected_d = model(cmd_op, cmd_a, cmd_b);
                    wait_cnt_d = '0;
                    if (cmd_count_q != 16'hFFFF) begin
                        cmd_count_d = cmd_count_q + 16'd1;
                    end
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // First WAIT edge is the ALU sampling edge; the result is
                // stable ALU_LATENCY edges after that.
                if (wait_cnt_q == CW'(ALU_LATENCY)) begin
                    result_d   = alu_result;
                    mismatch_d = (alu_result != expected_q);
                    if ((alu_result != expected_q) && (err_count_q != 16'hFFFF)) begin
                        err_count_d = err_count_q + 16'd1;
                    end
                    state_d = RESP;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            wait_cnt_q  <= '0;
            opcode_q    <= 4'h0;
            a_q         <= 8'h00;
            b_q         <= 8'h00;
            result_q    <= 9'h000;
            expected_q  <= 9'h000;
            mismatch_q  <= 1'b0;
            cmd_count_q <= 16'h0000;
            err_count_q <= 16'h0000;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            opcode_q    <= opcode_d;
            a_q         <= a_d;
            b_q         <= b_d;
            result_q    <= result_d;
            expected_q  <= expected_d;
            mismatch_q  <= mismatch_d;
            cmd_count_q <= cmd_count_d;
            err_count_q <= err_count_d;
        end
    end

    assign cmd_ready    = (state_q == IDLE);
    assign rsp_valid    = (state_q == RESP);
    assign alu_opcode   = opcode_q;
    assign alu_a        = a_q;
    assign alu_b        = b_q;
    assign rsp_result   = result_q;
    assign rsp_expected = expected_q;
    assign rsp_mismatch = mismatch_q;
    assign cmd_count    = cmd_count_q;
    assign err_count    = err_count_q;

endmodule

// File: tb/tb_alu_cmd_driver.sv
// tb_alu_cmd_driver: directed bench for alu_cmd_driver with a one-cycle ALU stand-in.
// Latency: ALU result registered one edge after alu_* are sampled.
// Backpressure: rsp_ready driven by the directed sequences.
module tb_alu_cmd_driver;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_op;
    logic [7:0]  cmd_a;
    logic [7:0]  cmd_b;
    logic [3:0]  alu_opcode;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [8:0]  alu_result;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [8:0]  rsp_result;
    logic [8:0]  rsp_expected;
    logic        rsp_mismatch;
    logic [15:0] cmd_count;
    logic [15:0] err_count;

    logic        fault;
    logic [8:0]  alu_q;
    int          n_pass;
    int          n_total;
    int          cyc;

    always #5 clk = ~clk;

    alu_cmd_driver #(.ALU_LATENCY(1)) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_a        (cmd_a),
        .cmd_b        (cmd_b),
        .alu_opcode   (alu_opcode),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_result   (alu_result),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_result   (rsp_result),
        .rsp_expected (rsp_expected),
        .rsp_mismatch (rsp_mismatch),
        .cmd_count    (cmd_count),
        .err_count    (err_count)
    );

    // ALU stand-in with a single register stage.
    always @(posedge clk) begin
        case (alu_opcode)
            4'b0000: alu_q <= {1'b0, alu_a} + {1'b0, alu_b};
            4'b0001: alu_q <= {1'b0, alu_a} - {1'b0, alu_b};
            4'b0010: alu_q <= {1'b0, alu_a & alu_b};
            4'b0011: alu_q <= {1'b0, alu_a | alu_b};
            4'b0100: alu_q <= {1'b0, alu_a ^ alu_b};
            default: alu_q <= 9'h000;
        endcase
    end
    assign alu_result = fault ? 9'h000 : alu_q;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Leaves the accept edge just behind us.
    task automatic accept(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        int n;
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 20) begin
            tick();
            n++;
        end
        check("accept_timeout", 16'(cmd_ready), 16'h1);
        tick();
        cmd_valid = 1'b0;
        check("alu_opcode", 16'(alu_opcode), 16'(op));
        check("alu_a", 16'(alu_a), 16'(a));
        check("alu_b", 16'(alu_b), 16'(b));
    endtask

    task automatic wait_rsp(output int lat);
        lat = 0;
        while (!rsp_valid && lat < 20) begin
            tick();
            lat++;
        end
        check("rsp_timeout", 16'(rsp_valid), 16'h1);
    endtask

    task automatic handshake();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("post_hs_rsp_valid", 16'(rsp_valid), 16'h0);
        check("post_hs_cmd_ready", 16'(cmd_ready), 16'h1);
    endtask

    task automatic run_cmd(input string tag, input logic [3:0] op, input logic [7:0] a,
                           input logic [7:0] b, input logic [8:0] exp_res,
                           input logic [8:0] exp_model, input logic exp_mis);
        int lat;
        accept(op, a, b);
        wait_rsp(lat);
        check({tag, "_latency"}, 16'(lat), 16'd2);
        check({tag, "_result"}, 16'(rsp_result), 16'(exp_res));
        check({tag, "_expected"}, 16'(rsp_expected), 16'(exp_model));
        check({tag, "_mismatch"}, 16'(rsp_mismatch), 16'(exp_mis));
        handshake();
    endtask

    initial begin
        int lat;
        int acc_cyc[4];
        int n_acc;
        logic [8:0] held;

        n_pass    = 0;
        n_total   = 0;
        cyc       = 0;
        fault     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 4'h0;
        cmd_a     = 8'h00;
        cmd_b     = 8'h00;
        rsp_ready = 1'b0;

        do_reset();
        check("rst_cmd_ready", 16'(cmd_ready), 16'h1);
        check("rst_rsp_valid", 16'(rsp_valid), 16'h0);
        check("rst_rsp_result", 16'(rsp_result), 16'h0);
        check("rst_rsp_expected", 16'(rsp_expected), 16'h0);
        check("rst_rsp_mismatch", 16'(rsp_mismatch), 16'h0);
        check("rst_alu_opcode", 16'(alu_opcode), 16'h0);
        check("rst_alu_a", 16'(alu_a), 16'h0);
        check("rst_alu_b", 16'(alu_b), 16'h0);
        check("rst_cmd_count", cmd_count, 16'h0);
        check("rst_err_count", err_count, 16'h0);

        run_cmd("add", 4'b0000, 8'hFF, 8'h01, 9'h100, 9'h100, 1'b0);
        check("add_cmd_count", cmd_count, 16'd1);
        run_cmd("sub", 4'b0001, 8'h05, 8'h07, 9'h1FE, 9'h1FE, 1'b0);
        run_cmd("unused", 4'b0111, 8'hAA, 8'h55, 9'h000, 9'h000, 1'b0);
        run_cmd("xor", 4'b0100, 8'hAA, 8'h55, 9'h0FF, 9'h0FF, 1'b0);
        check("cmd_count4", cmd_count, 16'd4);

        // Backpressure: hold rsp_ready low for 5 cycles with a stray command pulse.
        accept(4'b0011, 8'h0F, 8'hF0);
        wait_rsp(lat);
        held = rsp_result;
        check("bp_result", 16'(held), 16'h0FF);
        for (int i = 0; i < 5; i++) begin
            cmd_valid = (i == 1);
            tick();
            check("bp_rsp_valid", 16'(rsp_valid), 16'h1);
            check("bp_rsp_result", 16'(rsp_result), 16'(held));
            check("bp_cmd_ready", 16'(cmd_ready), 16'h0);
        end
        cmd_valid = 1'b0;
        check("bp_cmd_count", cmd_count, 16'd5);
        handshake();
        check("bp_cmd_count_after", cmd_count, 16'd5);

        // Fault injection.
        fault = 1'b1;
        run_cmd("fault", 4'b0010, 8'hF0, 8'h3C, 9'h000, 9'h030, 1'b1);
        fault = 1'b0;
        check("fault_err_count", err_count, 16'd1);
        run_cmd("post_fault", 4'b0000, 8'h01, 8'h02, 9'h003, 9'h003, 1'b0);
        check("post_fault_err_count", err_count, 16'd1);
        check("post_fault_cmd_count", cmd_count, 16'd7);

        // Reset while in WAIT.
        accept(4'b0000, 8'h10, 8'h20);
        check("mid_in_wait", 16'(cmd_ready), 16'h0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rsp_valid", 16'(rsp_valid), 16'h0);
        check("mid_cmd_ready", 16'(cmd_ready), 16'h1);
        check("mid_cmd_count", cmd_count, 16'h0);
        check("mid_err_count", err_count, 16'h0);
        check("mid_rsp_result", 16'(rsp_result), 16'h0);
        check("mid_alu_a", 16'(alu_a), 16'h0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("mid_no_rsp", 16'(rsp_valid), 16'h0);
        end
        run_cmd("after_mid", 4'b0001, 8'h30, 8'h10, 9'h020, 9'h020, 1'b0);
        check("after_mid_cmd_count", cmd_count, 16'd1);

        // Back-to-back with rsp_ready and cmd_valid held high.
        do_reset();
        cmd_op    = 4'b0000;
        cmd_a     = 8'h11;
        cmd_b     = 8'h22;
        cmd_valid = 1'b1;
        rsp_ready = 1'b1;
        n_acc     = 0;
        for (int i = 0; i < 40 && n_acc < 4; i++) begin
            if (cmd_ready) begin
                acc_cyc[n_acc] = cyc;
                n_acc++;
            end
            tick();
        end
        cmd_valid = 1'b0;
        check("b2b_accepts", 16'(n_acc), 16'd4);
        for (int i = 1; i < 4; i++) begin
            check("b2b_spacing", 16'(acc_cyc[i] - acc_cyc[i-1]), 16'd4);
        end
        wait_rsp(lat);
        check("b2b_result", 16'(rsp_result), 16'h033);
        tick();
        rsp_ready = 1'b0;
        check("b2b_idle", 16'(cmd_ready), 16'h1);
        check("b2b_cmd_count", cmd_count, 16'd4);
        check("b2b_err_count", err_count, 16'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/alu_cmd_driver.md
# alu_cmd_driver

Initiator side of the sequential ALU interface. Accepts ALU commands over a valid/ready stream, drives opcode and operands into the ALU, waits the ALU's fixed latency, and captures the 9-bit result. It also compares that result against an internal expected-value model and returns it with a mismatch flag over a valid/ready response stream. Sits between the test/command source and the ALU; one command outstanding at a time.

## Interface
- ALU_LATENCY, default 1: clock edges from the ALU sampling its inputs to its result being stable (min 1).
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  driver can accept a command
- cmd_op  in  4  ALU opcode
- cmd_a  in  8  operand A
- cmd_b  in  8  operand B
- alu_opcode  out  4  registered opcode to ALU
- alu_a  out  8  registered operand A to ALU
- alu_b  out  8  registered operand B to ALU
- alu_result  in  9  ALU result
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_result  out  9  captured alu_result
- rsp_expected  out  9  model result for the same command
- rsp_mismatch  out  1  rsp_result != rsp_expected
- cmd_count  out  16  accepted commands, saturating at 0xFFFF
- err_count  out  16  mismatching responses, saturating at 0xFFFF

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: cmd_ready=1. On cmd_valid&&cmd_ready, the following happens at that edge:
  - alu_opcode/alu_a/alu_b are loaded from cmd_*.
  - rsp_expected is loaded from the model.
  - cmd_count is incremented.
  - State goes to WAIT.
- WAIT: cmd_ready=0, cmd_valid ignored. After the required edges (see Timing), alu_result is captured into rsp_result, rsp_mismatch is computed, err_count increments if the result mismatches, and state goes to RESP.
- RESP: rsp_valid=1. rsp_result, rsp_expected and rsp_mismatch are held stable until rsp_valid&&rsp_ready. On that edge, state returns to IDLE.
- alu_* outputs hold their last value between commands.
- Expected model, with operands zero-extended to 9 bits:
  - 0000: A+B, full 9-bit sum.
  - 0001: A-B mod 512. Bit 8 is set when B>A; e.g. 5-7 = 0x1FE.
  - 0010: A&B. 0011: A|B. 0100: A^B.
  - Any other opcode: 0.
- Counters saturate and never wrap.

## Timing
- Reset values: state IDLE, cmd_ready=1 (first cycle after rst deasserts), rsp_valid=0, rsp_result=0, rsp_expected=0, rsp_mismatch=0, alu_opcode=0, alu_a=0, alu_b=0, cmd_count=0, err_count=0.
- Command accepted at edge N:
  - alu_* are valid after N.
  - The ALU samples them at N+1.
  - alu_result is captured at edge N+1+ALU_LATENCY.
  - rsp_valid is high from N+1+ALU_LATENCY.
- Response handshake at edge R gives IDLE after R. The earliest next accept is R+1.
- With rsp_ready held high, accepts occur every ALU_LATENCY+3 cycles.
- rsp_valid is never deasserted without a handshake. rsp_ready while rsp_valid=0 has no effect.
- Reset mid-operation (WAIT or RESP) behaves as follows:
  - The in-flight command is discarded and no response is produced.
  - All outputs take their reset values on the next edge.
  - Counters are cleared.
- The command counter and error counter may update on the same cycle only across different commands. There is no simultaneous accept and capture, since only one command is outstanding.

## Test plan
- ADD: cmd_op=0000, A=0xFF, B=0x01 accepted at edge N -> alu_opcode=0 after N; rsp_valid rises at edge N+2 (ALU_LATENCY=1); rsp_result=0x100, rsp_expected=0x100, rsp_mismatch=0, cmd_count=1.
- SUB borrow and unused opcode:
  - 0001, A=0x05, B=0x07 -> rsp_result=rsp_expected=0x1FE.
  - 0111, A=0xAA, B=0x55 -> rsp_result=rsp_expected=0x000.
  - 0100 on the same operands -> 0x0FF.
- Backpressure: hold rsp_ready=0 for 5 cycles after rsp_valid rises -> rsp_valid and rsp_result stay stable, cmd_ready=0, and a cmd_valid pulse is ignored (cmd_count unchanged). Then rsp_ready=1 -> handshake, and cmd_ready=1 the next cycle.
- Fault injection: 0010, A=0xF0, B=0x3C, with the bench forcing alu_result=0x000 -> rsp_expected=0x030, rsp_mismatch=1, err_count=1. The next correct command leaves err_count=1.
- Reset mid-operation: assert rst for one cycle while in WAIT -> no response is ever produced; after the reset edge rsp_valid=0, cmd_ready=1, and both counters are 0. The next command completes normally.
- Back-to-back: 4 commands with rsp_ready=1 and cmd_valid always high -> accepts spaced exactly 4 cycles apart, and cmd_count=4.
